// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one ripple-carry adder among NREQ requesters, one result held at a time.
// Optional subtract support is enabled by defining ADDER_ARBITER_SUB_EN (adds the req_sub port).
//
// state | meaning
// IDLE  | no result held, resp_valid low
// HOLD  | result held in resp_* registers, resp_valid high
module adder_arbiter #(
   parameter int DATA_W = 32,
   parameter int NREQ   = 3
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NREQ-1:0]        req_valid,
   output logic [NREQ-1:0]        req_ready,
   input  logic [NREQ*DATA_W-1:0] req_a,
   input  logic [NREQ*DATA_W-1:0] req_b,
`ifdef ADDER_ARBITER_SUB_EN
   input  logic [NREQ-1:0]        req_sub,
`endif
   output logic                   resp_valid,
   input  logic                   resp_ready,
   output logic [1:0]             resp_id,
   output logic [DATA_W-1:0]      resp_sum,
   output logic                   resp_carry
);

   typedef enum logic {IDLE, HOLD} state_t;

   state_t            state_q, state_d;
   logic [1:0]        last_grant_q, last_grant_d;
   logic [1:0]        resp_id_q, resp_id_d;
   logic [DATA_W-1:0] resp_sum_q, resp_sum_d;
   logic              resp_carry_q, resp_carry_d;

   logic              found;
   logic [1:0]        gnt_idx;
   logic [1:0]        start;
   logic [2:0]        cand;
   logic              accept;
   logic              transfer;
   logic [DATA_W-1:0] a_sel, b_sel, b_eff, sum;
   logic              sub_sel;
   logic              carry;

   // Round-robin search starting one past the last granted requester.
   always_comb begin
      found   = 1'b0;
      gnt_idx = 2'd0;
      cand    = 3'd0;
      start   = (last_grant_q == 2'(NREQ-1)) ? 2'd0 : last_grant_q + 2'd1;
      for (int k = 0; k < NREQ; k++) begin
         cand = {1'b0, start} + 3'(k);
         if (cand >= 3'(NREQ)) cand = cand - 3'(NREQ);
         if (!found && req_valid[cand[1:0]]) begin
            found   = 1'b1;
            gnt_idx = cand[1:0];
         end
      end
   end

   always_comb begin
      accept   = !rst && ((state_q == IDLE) || resp_ready);
      transfer = accept && found;
      req_ready = '0;
      if (transfer) req_ready[gnt_idx] = 1'b1;
   end

   always_comb begin
      a_sel = '0;
      b_sel = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (gnt_idx == 2'(i)) begin
            a_sel = req_a[i*DATA_W +: DATA_W];
            b_sel = req_b[i*DATA_W +: DATA_W];
         end
      end
`ifdef ADDER_ARBITER_SUB_EN
      sub_sel = req_sub[gnt_idx];
`else
      sub_sel = 1'b0;
`endif
   end

   // Subtraction reuses the adder as A + ~B + 1; carry out then means no borrow.
   always_comb begin
      b_eff = sub_sel ? ~b_sel : b_sel;
      carry = sub_sel;
      sum   = '0;
      for (int i = 0; i < DATA_W; i++) begin
         sum[i] = a_sel[i] ^ b_eff[i] ^ carry;
         carry  = (a_sel[i] & b_eff[i]) | (carry & (a_sel[i] ^ b_eff[i]));
      end
   end

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      resp_id_d    = resp_id_q;
      resp_sum_d   = resp_sum_q;
      resp_carry_d = resp_carry_q;
      if (transfer) begin
         state_d      = HOLD;
         last_grant_d = gnt_idx;
         resp_id_d    = gnt_idx;
         resp_sum_d   = sum;
         resp_carry_d = carry;
      end else if ((state_q == HOLD) && resp_ready) begin
         state_d = IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         last_grant_q <= 2'(NREQ-1);
         resp_id_q    <= 2'd0;
         resp_sum_q   <= '0;
         resp_carry_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         resp_id_q    <= resp_id_d;
         resp_sum_q   <= resp_sum_d;
         resp_carry_q <= resp_carry_d;
      end
   end

   assign resp_valid = (state_q == HOLD);
   assign resp_id    = resp_id_q;
   assign resp_sum   = resp_sum_q;
   assign resp_carry = resp_carry_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// Scoreboard bench for adder_arbiter: directed scenarios followed by random valid/ready traffic.
// A reference model predicts grants and results; a separate monitor checks each delivered response.
module tb_adder_arbiter;
   localparam int DW = 32;
   localparam int NR = 3;

   logic              clk = 1'b0;
   logic              rst;
   logic [NR-1:0]     req_valid;
   logic [NR-1:0]     req_ready;
   logic [NR*DW-1:0]  req_a, req_b;
   logic [NR-1:0]     req_sub;
   logic              resp_valid, resp_ready, resp_carry;
   logic [1:0]        resp_id;
   logic [DW-1:0]     resp_sum;

   int n_cmp  = 0;
   int n_fail = 0;

   logic [34:0] sb[$];

   adder_arbiter #(.DATA_W(DW), .NREQ(NR)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b),
`ifdef ADDER_ARBITER_SUB_EN
      .req_sub(req_sub),
`endif
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_id(resp_id), .resp_sum(resp_sum), .resp_carry(resp_carry)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [1:0] nxt(input logic [1:0] x);
      return (x == 2'd2) ? 2'd0 : x + 2'd1;
   endfunction

   // Reference model: evaluated at negedge, when inputs for the coming edge are stable.
   logic       model_hold = 1'b0;
   logic [1:0] model_last = 2'd2;
   int         wait_cnt[NR];

   always @(negedge clk) begin
      logic [1:0]  idx, g;
      logic        have;
      logic [NR-1:0] exp_ready;
      logic [DW-1:0] a, b;
      logic [32:0] s;
      logic        sub;
      if (rst) begin
         check("ready_in_reset", 64'(req_ready), 64'(0));
         model_hold = 1'b0;
         model_last = 2'd2;
         sb.delete();
         for (int i = 0; i < NR; i++) wait_cnt[i] = 0;
      end else begin
         check("resp_valid_state", 64'(resp_valid), 64'(model_hold));
         have = 1'b0;
         g    = 2'd0;
         idx  = nxt(model_last);
         for (int k = 0; k < NR; k++) begin
            if (!have && req_valid[idx]) begin
               have = 1'b1;
               g    = idx;
            end
            idx = nxt(idx);
         end
         exp_ready = (have && (!model_hold || resp_ready)) ? (3'b001 << g) : 3'b000;
         check("req_ready", 64'(req_ready), 64'(exp_ready));
         check("ready_onehot0", 64'($countones(req_ready) <= 1), 64'(1));
         for (int i = 0; i < NR; i++) if (!req_valid[i]) wait_cnt[i] = 0;
         if (exp_ready != 3'b000) begin
            a = 32'(req_a >> (DW * int'(g)));
            b = 32'(req_b >> (DW * int'(g)));
            sub = req_sub[g];
`ifdef ADDER_ARBITER_SUB_EN
`else
            sub = 1'b0;
`endif
            if (sub) begin
               s[31:0] = a - b;
               s[32]   = (a >= b);
            end else begin
               s = {1'b0, a} + {1'b0, b};
            end
            sb.push_back({g, s});
            for (int i = 0; i < NR; i++) begin
               if (i == int'(g)) wait_cnt[i] = 0;
               else if (req_valid[i]) wait_cnt[i]++;
               check("no_starve", 64'(wait_cnt[i] <= 2), 64'(1));
            end
            model_last = g;
            model_hold = 1'b1;
         end else if (model_hold && resp_ready) begin
            model_hold = 1'b0;
         end
      end
   end

   // Monitor: pops the scoreboard on each response handshake and checks hold stability.
   logic        prev_stall = 1'b0;
   logic [34:0] prev_out;

   always @(negedge clk) begin
      logic [34:0] e;
      if (!rst && resp_valid) begin
         if (prev_stall) check("hold_stable", 64'({resp_id, resp_carry, resp_sum}), 64'(prev_out));
         if (resp_ready) begin
            if (sb.size() == 0) begin
               check("sb_nonempty", 64'(0), 64'(1));
            end else begin
               e = sb.pop_front();
               check("resp_id", 64'(resp_id), 64'(e[34:33]));
               check("resp_carry", 64'(resp_carry), 64'(e[32]));
               check("resp_sum", 64'(resp_sum), 64'(e[31:0]));
            end
         end
      end
      prev_stall = !rst && resp_valid && !resp_ready;
      prev_out   = {resp_id, resp_carry, resp_sum};
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ops(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b);
      req_a[i*DW +: DW] = a;
      req_b[i*DW +: DW] = b;
   endtask

   task automatic rand_ops();
      for (int i = 0; i < NR; i++) begin
         set_ops(i, ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : 32'($urandom),
                    ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : 32'($urandom));
      end
   endtask

   logic [NR-1:0] exp_seq[4];

   initial begin
      rst = 1'b1; req_valid = '0; resp_ready = 1'b0; req_a = '0; req_b = '0; req_sub = '0;
      tick();
      @(negedge clk);
      check("rst_resp_valid", 64'(resp_valid), 64'(0));
      check("rst_resp_id", 64'(resp_id), 64'(0));
      check("rst_resp_sum", 64'(resp_sum), 64'(0));
      check("rst_resp_carry", 64'(resp_carry), 64'(0));
      tick();
      rst = 1'b0;

      // Round-robin order 0,1,2,0 with no bubble.
      exp_seq[0] = 3'b001; exp_seq[1] = 3'b010; exp_seq[2] = 3'b100; exp_seq[3] = 3'b001;
      req_valid = 3'b111; resp_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         rand_ops();
         @(negedge clk);
         check("rr_order", 64'(req_ready), 64'(exp_seq[k]));
         if (k > 0) check("rr_no_bubble", 64'(resp_valid), 64'(1));
         tick();
      end
      req_valid = '0;
      tick();

      // Carry-out wrap on requester 1; later operand changes must not leak.
      req_valid = 3'b010;
      set_ops(1, 32'hFFFF_FFFF, 32'h0000_0001);
      @(negedge clk);
      check("wrap_grant", 64'(req_ready), 64'(3'b010));
      tick();
      req_valid = '0; resp_ready = 1'b0;
      rand_ops();
      @(negedge clk);
      check("wrap_sum", 64'(resp_sum), 64'(0));
      check("wrap_carry", 64'(resp_carry), 64'(1));
      check("wrap_id", 64'(resp_id), 64'(1));
      tick();
      resp_ready = 1'b1;
      tick();

      // Backpressure for 5 cycles, then requester 2 is granted on release.
      req_valid = 3'b001;
      tick();
      req_valid = 3'b100; resp_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("stall_ready", 64'(req_ready), 64'(0));
         tick();
      end
      resp_ready = 1'b1;
      @(negedge clk);
      check("release_grant", 64'(req_ready), 64'(3'b100));
      tick();

      // Reset while holding, with requester 0 pending.
      req_valid = 3'b001; resp_ready = 1'b0; rst = 1'b1;
      tick();
      rst = 1'b0;
      @(negedge clk);
      check("rst_hold_valid", 64'(resp_valid), 64'(0));
      check("rst_first_grant", 64'(req_ready), 64'(3'b001));
      resp_ready = 1'b1;
      tick();
      req_valid = '0;
      tick();

`ifdef ADDER_ARBITER_SUB_EN
      req_valid = 3'b001; req_sub = 3'b001; set_ops(0, 32'd5, 32'd7);
      tick();
      req_valid = '0;
      @(negedge clk);
      check("sub_neg_sum", 64'(resp_sum), 64'(32'hFFFF_FFFE));
      check("sub_neg_carry", 64'(resp_carry), 64'(0));
      tick();
      req_valid = 3'b001; set_ops(0, 32'd7, 32'd5);
      tick();
      req_valid = '0;
      @(negedge clk);
      check("sub_pos_sum", 64'(resp_sum), 64'(2));
      check("sub_pos_carry", 64'(resp_carry), 64'(1));
      tick();
      req_sub = '0;
      tick();
`endif

      // Random traffic.
      for (int n = 0; n < 3000; n++) begin
         req_valid  = 3'($urandom_range(0, 7));
         resp_ready = ($urandom_range(0, 3) != 0);
         req_sub    = 3'($urandom_range(0, 7));
         rst        = ($urandom_range(0, 199) == 0);
         rand_ops();
         tick();
      end
      rst = 1'b0; req_valid = '0; resp_ready = 1'b1;
      repeat (3) tick();
      @(negedge clk);
      check("drain_empty", 64'(sb.size()), 64'(0));
      check("drain_idle", 64'(resp_valid), 64'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule

// File: doc/adder_arbiter.md
ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 Parameter DATA_W, default 32: operand and sum width in bits.
REQ-002 Parameter NREQ, fixed at 3: number of requesters. Other values are unsupported.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req_valid  input  NREQ  per-requester operation request.
REQ-006 req_ready  output  NREQ  per-requester accept; one-hot or zero.
REQ-007 req_a  input  NREQ*DATA_W  operand A, flattened; requester i occupies bits [i*DATA_W +: DATA_W].
REQ-008 req_b  input  NREQ*DATA_W  operand B, flattened, same packing as req_a.
REQ-009 resp_valid  output  1  result available.
REQ-010 resp_ready  input  1  consumer accepts the result.
REQ-011 resp_id  output  2  index of the requester that owns the result.
REQ-012 resp_sum  output  DATA_W  sum.
REQ-013 resp_carry  output  1  carry out of the MSB.

Function
REQ-014 The block shall time-share one DATA_W-bit ripple adder among NREQ requesters, with one operation outstanding at a time.
REQ-015 States: IDLE (no result held) and HOLD (result held, resp_valid=1).
REQ-016 Transfer on requester i occurs when req_valid[i] & req_ready[i] at a rising edge.
REQ-017 req_ready[i] shall be 1 only for the granted requester, and only while (state==IDLE) or (state==HOLD & resp_ready).
REQ-018 Grant is combinational, round-robin.
  - Priority starts at (last_grant+1) mod NREQ.
  - Only requesters with req_valid=1 are eligible.
REQ-019 last_grant shall update only on a transfer.
REQ-020 Latency:
  - A transfer at edge N loads {carry,sum}=A+B into registers and sets resp_valid from edge N.
  - resp_id = granted index.
REQ-021 Arithmetic: {resp_carry,resp_sum} = zero-extended A + zero-extended B, DATA_W+1 bits, with no overflow flag.
REQ-022 While HOLD & !resp_ready:
  - resp_valid, resp_id, resp_sum and resp_carry shall be held stable.
  - req_ready shall be 0.
REQ-023 Transitions:
  - HOLD & resp_ready & no request: go to IDLE, resp_valid drops next cycle.
  - HOLD & resp_ready & a request: new transfer same edge, remain in HOLD with the new result (back-to-back, no bubble).
REQ-024 IDLE & no req_valid: stay in IDLE; req_ready=0.
REQ-025 A requester that drops req_valid before a transfer shall lose eligibility without side effect.
REQ-026 Operands shall be sampled only on the transfer edge. Later operand changes shall not affect the held result.

Reset
REQ-027 While rst=1 at a rising edge:
  - state <= IDLE
  - resp_valid <= 0
  - resp_id <= 0
  - resp_sum <= 0
  - resp_carry <= 0
  - last_grant <= NREQ-1, so requester 0 has highest priority after reset.
REQ-028 req_ready shall be 0 while rst=1.
REQ-029 Reset mid-HOLD shall discard the held result with no response delivered. Reset wins over a simultaneous transfer.

Configuration
REQ-030 Macro ADDER_ARBITER_SUB_EN controls subtract support.
REQ-031 With ADDER_ARBITER_SUB_EN defined:
  - Input port req_sub (NREQ bits) exists.
  - A transfer with req_sub[i]=1 computes A + ~B + 1.
  - resp_carry is then 1 when A >= B (no borrow).
REQ-032 Without ADDER_ARBITER_SUB_EN: port req_sub is absent and all operations are addition.

Verification
REQ-033 Reset then req_valid=3'b111, resp_ready=1.
  - Grants in order 0,1,2,0 on consecutive cycles.
  - resp_valid stays 1 continuously with no bubble.
REQ-034 Requester 1: A=32'hFFFF_FFFF, B=32'h0000_0001 -> resp_sum=0, resp_carry=1, resp_id=1, one edge after transfer.
REQ-035 HOLD with resp_ready=0 for 5 cycles while req_valid[2]=1 -> req_ready=0 and outputs stable. On resp_ready=1, requester 2 is granted that same edge.
REQ-036 rst asserted during HOLD with req_valid[0]=1 -> next cycle resp_valid=0, no transfer. After release, requester 0 is granted first.
REQ-037 With ADDER_ARBITER_SUB_EN: A=5, B=7, req_sub=1 -> resp_sum=32'hFFFF_FFFE, resp_carry=0. With A=7, B=5 -> resp_sum=2, resp_carry=1.
REQ-038 Random valid/ready traffic: checker confirms req_ready is one-hot-or-zero, no requester starves beyond 2 grants to others, and every result equals the reference A+B.
